// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared types and elaboration helpers for the PWM DAC player.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } dac_state_t;

    // Clocks between sample releases.
    function automatic int calc_sample_div(input int clock_freq, input int sample_rate);
        return clock_freq / sample_rate;
    endfunction

    function automatic int calc_samp_cnt_w(input int sample_div);
        return (sample_div > 1) ? $clog2(sample_div) : 1;
    endfunction

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_dac_player_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_dac_player_if
//  Description : Valid/ready sample stream into the PWM DAC player.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_dac_player_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface : pwm_dac_player_if
`default_nettype wire

// File: rtl/pwm_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_sample_fifo
//  Description : Synchronous sample FIFO with combinational head data.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_data,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_data,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH+1)-1:0] o_level
);
    localparam int C_AW = $clog2(DEPTH);
    localparam int C_LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_LW-1:0]  r_level;
    logic             w_do_push;
    logic             w_do_pop;

    // Full blocks pushes even when a pop happens the same cycle.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
            else if (!w_do_push && w_do_pop) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_level == C_LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule : pwm_sample_fifo
`default_nettype wire

// File: rtl/pwm_dac_player.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_dac_player
//  Description : Plays FIFO-buffered sample codes as a glitch-free PWM stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_dac_player
    import pwm_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int CLOCK_FREQ  = 100_000_000,
    parameter int SAMPLE_RATE = 1000
) (
    input  wire logic                              clk,
    input  wire logic                              reset,
    input  wire logic                              enable,
    pwm_dac_player_if.slave                        s_if,
    input  wire logic                              clear_flags,
    output logic                                   pwm_out,
    output logic [WIDTH-1:0]                       duty_now,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_level,
    output logic                                   underflow,
    output logic                                   busy
);
    localparam int                    C_SAMPLE_DIV = calc_sample_div(CLOCK_FREQ, SAMPLE_RATE);
    localparam int                    C_SAMP_W     = calc_samp_cnt_w(C_SAMPLE_DIV);
    localparam logic [WIDTH-1:0]      C_PWM_LAST   = '1;
    localparam logic [C_SAMP_W-1:0]   C_SAMP_LAST  = C_SAMP_W'(C_SAMPLE_DIV - 1);

    dac_state_t            r_state;
    dac_state_t            w_next_state;
    logic [WIDTH-1:0]      r_pwm_cnt;
    logic [C_SAMP_W-1:0]   r_samp_cnt;
    logic                  r_pending;
    logic                  r_pwm_out;
    logic [WIDTH-1:0]      r_duty;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic [WIDTH-1:0]      w_head;
    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_sample_due;
    logic                  w_pop;
    logic                  w_clr;
    logic                  w_run_cnt;
    logic                  w_uf_set;

    pwm_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (s_if.s_valid),
        .i_data  (s_if.s_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign s_if.s_ready = ~w_full;

    // A tick landing on the wrap cycle is served immediately, otherwise it waits as pending.
    assign w_tick       = (r_samp_cnt == C_SAMP_LAST);
    assign w_wrap       = (r_pwm_cnt == C_PWM_LAST);
    assign w_sample_due = w_wrap & (r_pending | w_tick);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_clr        = 1'b0;
        w_run_cnt    = 1'b0;
        w_uf_set     = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (enable) w_next_state = PRIME;
            end
            PRIME: begin
                w_clr = 1'b1;
                if (!enable) begin
                    w_next_state = IDLE;
                end else if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    w_clr        = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_run_cnt = 1'b1;
                    if (w_sample_due) begin
                        w_pop    = ~w_empty;
                        w_uf_set = w_empty;
                    end
                end
            end
            default: begin
                w_clr        = 1'b1;
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt   <= '0;
            r_samp_cnt  <= '0;
            r_pending   <= 1'b0;
            r_pwm_out   <= 1'b0;
            r_duty      <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_clr) begin
                r_pwm_cnt  <= '0;
                r_samp_cnt <= '0;
                r_pending  <= 1'b0;
                r_pwm_out  <= 1'b0;
            end else if (w_run_cnt) begin
                r_pwm_cnt  <= r_pwm_cnt + 1'b1;
                r_samp_cnt <= w_tick ? '0 : r_samp_cnt + 1'b1;
                r_pwm_out  <= (r_pwm_cnt < r_duty);
                if (w_sample_due) r_pending <= 1'b0;
                else if (w_tick)  r_pending <= 1'b1;
            end
            // Loads only at PRIME exit or period end, so the new duty starts at pwm_cnt 0.
            if (w_pop) r_duty <= w_head;
            if (w_uf_set)         r_underflow <= 1'b1;
            else if (clear_flags) r_underflow <= 1'b0;
        end
    end

    assign pwm_out   = r_pwm_out;
    assign duty_now  = r_duty;
    assign underflow = r_underflow;
    assign busy      = (r_state != IDLE);

endmodule : pwm_dac_player
`default_nettype wire

// File: tb/tb_pwm_dac_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_dac_player
//  Description : Scoreboard bench for pwm_dac_player (SAMPLE_DIV = 512 clocks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_dac_player;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clear_flags = 1'b0;
    logic       pwm_out;
    logic [7:0] duty_now;
    logic [4:0] fifo_level;
    logic       underflow;
    logic       busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb[$];

    pwm_dac_player_if #(.WIDTH(8)) sif ();

    pwm_dac_player #(
        .WIDTH       (8),
        .FIFO_DEPTH  (16),
        .CLOCK_FREQ  (2560),
        .SAMPLE_RATE (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .s_if        (sif),
        .clear_flags (clear_flags),
        .pwm_out     (pwm_out),
        .duty_now    (duty_now),
        .fifo_level  (fifo_level),
        .underflow   (underflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic push_one(input logic [7:0] d);
        bit ok = 1'b0;
        @(negedge clk);
        sif.s_data  = d;
        sif.s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sif.s_ready) begin
                @(posedge clk);
                ok = 1'b1;
                sb.push_back(d);
                break;
            end
            @(negedge clk);
        end
        #1 sif.s_valid = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL push_timeout: accepted=%0d required=1", ok);
        end
    endtask

    task automatic wait_pop(output bit ok);
        logic [4:0] prev = fifo_level;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (fifo_level < prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out === 1'b1) hi++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        reset       = 1'b1;
        enable      = 1'b0;
        sif.s_valid = 1'b0;
        clear_flags = 1'b0;
        #1;
        n_tests++; if (pwm_out !== 1'b0)     begin n_fail++; $display("FAIL rst_pwm: got %b req 0", pwm_out); end
        n_tests++; if (fifo_level !== 5'd0)  begin n_fail++; $display("FAIL rst_level: got %0d req 0", fifo_level); end
        n_tests++; if (sif.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b req 1", sif.s_ready); end
        n_tests++; if (underflow !== 1'b0)   begin n_fail++; $display("FAIL rst_underflow: got %b req 0", underflow); end
        n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b req 0", busy); end
        n_tests++; if (duty_now !== 8'h00)   begin n_fail++; $display("FAIL rst_duty: got %0h req 0", duty_now); end
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_single_sample();
        bit ok; int hi; logic [7:0] exp;
        push_one(8'h40);
        @(negedge clk);
        enable = 1'b1;
        wait_pop(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_prime_timeout: popped=%0d req 1", ok); end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_tests++; if (duty_now !== exp) begin n_fail++; $display("FAIL single_duty: got %0h req %0h", duty_now, exp); end
        for (int p = 0; p < 2; p++) begin
            count_high(256, hi);
            n_tests++; if (hi != 64) begin n_fail++; $display("FAIL single_high_p%0d: got %0d req 64", p, hi); end
        end
        n_tests++; if (duty_now !== 8'h40) begin n_fail++; $display("FAIL single_hold: got %0h req 40", duty_now); end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok; int acc = 0; bit rdy; logic [7:0] exp; int hi;
        @(negedge clk);
        sif.s_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            sif.s_data = 8'(8'h10 + i);
            rdy = sif.s_ready;
            @(posedge clk);
            if (rdy) begin
                acc++;
                sb.push_back(sif.s_data);
            end
            @(negedge clk);
        end
        sif.s_valid = 1'b0;
        n_tests++; if (acc != 16)             begin n_fail++; $display("FAIL b2b_accepted: got %0d req 16", acc); end
        n_tests++; if (sif.s_ready !== 1'b0)  begin n_fail++; $display("FAIL b2b_ready_full: got %b req 0", sif.s_ready); end
        n_tests++; if (fifo_level !== 5'd16)  begin n_fail++; $display("FAIL b2b_level: got %0d req 16", fifo_level); end
        enable = 1'b1;
        wait_pop(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_prime_timeout: popped=%0d req 1", ok); end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_tests++; if (duty_now !== exp) begin n_fail++; $display("FAIL b2b_first: got %0h req %0h", duty_now, exp); end
        count_high(512, hi);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_tests++; if (duty_now !== exp)     begin n_fail++; $display("FAIL b2b_second: got %0h req %0h", duty_now, exp); end
        n_tests++; if (fifo_level !== 5'd14) begin n_fail++; $display("FAIL b2b_level2: got %0d req 14", fifo_level); end
    endtask

    task automatic test_underflow();
        bit ok; int hi; logic [7:0] exp;
        push_one(8'h80);
        push_one(8'h20);
        @(negedge clk);
        enable = 1'b1;
        wait_pop(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL uf_prime_timeout: popped=%0d req 1", ok); end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_tests++; if (duty_now !== exp) begin n_fail++; $display("FAIL uf_duty0: got %0h req %0h", duty_now, exp); end
        for (int p = 0; p < 2; p++) begin
            count_high(256, hi);
            n_tests++; if (hi != 128) begin n_fail++; $display("FAIL uf_high80_p%0d: got %0d req 128", p, hi); end
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_tests++; if (duty_now !== exp)    begin n_fail++; $display("FAIL uf_duty1: got %0h req %0h", duty_now, exp); end
        n_tests++; if (underflow !== 1'b0)  begin n_fail++; $display("FAIL uf_early: got %b req 0", underflow); end
        for (int p = 0; p < 2; p++) begin
            count_high(256, hi);
            n_tests++; if (hi != 32) begin n_fail++; $display("FAIL uf_high20_p%0d: got %0d req 32", p, hi); end
        end
        n_tests++; if (underflow !== 1'b1)  begin n_fail++; $display("FAIL uf_set: got %b req 1", underflow); end
        n_tests++; if (duty_now !== 8'h20)  begin n_fail++; $display("FAIL uf_hold: got %0h req 20", duty_now); end
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        n_tests++; if (underflow !== 1'b0)  begin n_fail++; $display("FAIL uf_clear: got %b req 0", underflow); end
        clear_flags = 1'b1;
        repeat (511) @(negedge clk);
        n_tests++; if (underflow !== 1'b1)  begin n_fail++; $display("FAIL uf_set_beats_clear: got %b req 1", underflow); end
        clear_flags = 1'b0;
    endtask

    task automatic test_extremes();
        bit ok; int hi; logic [7:0] exp;
        push_one(8'h00);
        push_one(8'hFF);
        @(negedge clk);
        enable = 1'b1;
        wait_pop(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ext_prime_timeout: popped=%0d req 1", ok); end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_tests++; if (duty_now !== exp) begin n_fail++; $display("FAIL ext_duty00: got %0h req %0h", duty_now, exp); end
        count_high(512, hi);
        n_tests++; if (hi != 0) begin n_fail++; $display("FAIL ext_zero_high: got %0d req 0", hi); end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_tests++; if (duty_now !== exp) begin n_fail++; $display("FAIL ext_dutyff: got %0h req %0h", duty_now, exp); end
        for (int p = 0; p < 2; p++) begin
            count_high(256, hi);
            n_tests++; if (hi != 255) begin n_fail++; $display("FAIL ext_full_high_p%0d: got %0d req 255", p, hi); end
        end
    endtask

    task automatic test_async_reset();
        bit ok; logic [7:0] exp;
        push_one(8'hC0);
        push_one(8'hC0);
        @(negedge clk);
        enable = 1'b1;
        wait_pop(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ar_prime_timeout: popped=%0d req 1", ok); end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_tests++; if (duty_now !== exp) begin n_fail++; $display("FAIL ar_duty: got %0h req %0h", duty_now, exp); end
        repeat (10) @(negedge clk);
        n_tests++; if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL ar_pwm_high: got %b req 1", pwm_out); end
        enable = 1'b0;
        @(negedge clk);
        n_tests++; if (pwm_out !== 1'b0)   begin n_fail++; $display("FAIL dis_pwm: got %b req 0", pwm_out); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL dis_busy: got %b req 0", busy); end
        n_tests++; if (duty_now !== 8'hC0) begin n_fail++; $display("FAIL dis_duty_hold: got %0h req c0", duty_now); end
        enable = 1'b1;
        wait_pop(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ar_reprime_timeout: popped=%0d req 1", ok); end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_tests++; if (duty_now !== exp) begin n_fail++; $display("FAIL ar_duty2: got %0h req %0h", duty_now, exp); end
        repeat (10) @(negedge clk);
        push_one(8'h55);
        n_tests++; if (pwm_out !== 1'b1)    begin n_fail++; $display("FAIL ar_pwm_pre: got %b req 1", pwm_out); end
        n_tests++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL ar_level_pre: got %0d req 1", fifo_level); end
        @(negedge clk);
        #2;
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        n_tests++; if (pwm_out !== 1'b0)    begin n_fail++; $display("FAIL ar_pwm: got %b req 0", pwm_out); end
        n_tests++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL ar_level: got %0d req 0", fifo_level); end
        n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL ar_busy: got %b req 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL ar_idle_after: got %b req 0", busy); end
        n_tests++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL ar_pwm_after: got %b req 0", pwm_out); end
    endtask

    initial begin
        sif.s_data  = 8'h00;
        sif.s_valid = 1'b0;
        test_reset();
        test_single_sample();
        test_back_to_back();
        test_reset();
        test_underflow();
        test_reset();
        test_extremes();
        test_reset();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pwm_dac_player
`default_nettype wire
